// File: rtl/btb_predictor_if.sv
// rtl/btb_predictor_if.sv - lookup/update/invalidate bundle between the IF stage and the branch target buffer
interface btb_predictor_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] lookup_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              update_en;
    logic [ADDR_W-1:0] update_pc;
    logic              update_taken;
    logic [ADDR_W-1:0] update_target;
    logic              invalidate;
    logic              busy;
    logic [15:0]       stat_lookups;
    logic [15:0]       stat_hits;

    modport master (
        output lookup_pc, update_en, update_pc, update_taken, update_target, invalidate,
        input  pred_hit, pred_taken, pred_target, busy, stat_lookups, stat_hits
    );

    modport slave (
        input  lookup_pc, update_en, update_pc, update_taken, update_target, invalidate,
        output pred_hit, pred_taken, pred_target, busy, stat_lookups, stat_hits
    );
endinterface

// File: rtl/btb_predictor.sv
// rtl/btb_predictor.sv - direct-mapped BTB with saturating-counter direction predictor and invalidate sequencer
// Optional lookup/hit statistics counters are built when BTB_STATS_EN is defined.
module btb_predictor #(
    parameter int ADDR_W = 16,
    parameter int IDX_W  = 4,
    parameter int CTR_W  = 2
) (
    input  logic           clk,
    input  logic           pc_reset,
    btb_predictor_if.slave bus
);
    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = ADDR_W - IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(2 ** (CTR_W - 1));

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;

    logic               valid_q  [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];

    logic [IDX_W-1:0]   lk_idx, up_idx;
    logic [TAG_W-1:0]   lk_tag, up_tag;
    logic               busy, up_hit;

    assign busy   = (state_q == S_CLEAR);
    assign lk_idx = bus.lookup_pc[IDX_W-1:0];
    assign lk_tag = bus.lookup_pc[ADDR_W-1:IDX_W];
    assign up_idx = bus.update_pc[IDX_W-1:0];
    assign up_tag = bus.update_pc[ADDR_W-1:IDX_W];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Lookup reads the registered table, so a same-cycle update is seen only next cycle.
    assign bus.busy        = busy;
    assign bus.pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && !busy;
    assign bus.pred_taken  = bus.pred_hit && ctr_q[lk_idx][CTR_W-1];
    assign bus.pred_target = bus.pred_taken ? target_q[lk_idx] : bus.lookup_pc + ADDR_W'(1);

    always_ff @(posedge clk or posedge pc_reset) begin
        if (pc_reset) begin
            state_q   <= S_IDLE;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            S_IDLE: begin
                if (bus.invalidate) begin
                    state_d   = S_CLEAR;
                    clr_idx_d = '0;
                end
            end
            S_CLEAR: begin
                clr_idx_d = clr_idx_q + IDX_W'(1);
                if (clr_idx_q == IDX_W'(ENTRIES - 1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge pc_reset) begin
        if (pc_reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else if (busy) begin
            valid_q[clr_idx_q] <= 1'b0;
        end else if (bus.update_en) begin
            if (up_hit) begin
                if (bus.update_taken) begin
                    if (ctr_q[up_idx] != CTR_MAX) ctr_q[up_idx] <= ctr_q[up_idx] + CTR_W'(1);
                    target_q[up_idx] <= bus.update_target;
                end else if (ctr_q[up_idx] != '0) begin
                    ctr_q[up_idx] <= ctr_q[up_idx] - CTR_W'(1);
                end
            end else if (bus.update_taken) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= bus.update_target;
                ctr_q[up_idx]    <= CTR_WEAK;
            end
        end
    end

`ifdef BTB_STATS_EN
    logic [15:0] lookups_q, lookups_d, hits_q, hits_d;

    always_comb begin
        lookups_d = lookups_q;
        hits_d    = hits_q;
        if (!busy && lookups_q != 16'hFFFF) lookups_d = lookups_q + 16'd1;
        if (bus.pred_hit && hits_q != 16'hFFFF) hits_d = hits_q + 16'd1;
    end

    always_ff @(posedge clk or posedge pc_reset) begin
        if (pc_reset) begin
            lookups_q <= '0;
            hits_q    <= '0;
        end else begin
            lookups_q <= lookups_d;
            hits_q    <= hits_d;
        end
    end

    assign bus.stat_lookups = lookups_q;
    assign bus.stat_hits    = hits_q;
`else
    assign bus.stat_lookups = 16'h0000;
    assign bus.stat_hits    = 16'h0000;
`endif
endmodule

// File: tb/tb_btb_predictor.sv
// tb/tb_btb_predictor.sv - directed self-checking bench for btb_predictor
module tb_btb_predictor;
    logic clk = 1'b0;
    logic pc_reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    btb_predictor_if #(.ADDR_W(16)) bus ();

    btb_predictor #(.ADDR_W(16), .IDX_W(4), .CTR_W(2)) u_dut (
        .clk      (clk),
        .pc_reset (pc_reset),
        .bus      (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic upd(input logic [15:0] pc, input logic tk, input logic [15:0] tgt);
        @(negedge clk);
        bus.update_en     = 1'b1;
        bus.update_pc     = pc;
        bus.update_taken  = tk;
        bus.update_target = tgt;
        @(negedge clk);
        bus.update_en     = 1'b0;
    endtask

    task automatic look(input logic [15:0] pc);
        @(negedge clk);
        bus.lookup_pc = pc;
        #1;
    endtask

    int          cnt;
    logic [15:0] sl0, sh0;

    initial begin
        pc_reset          = 1'b1;
        bus.lookup_pc     = 16'h0040;
        bus.update_en     = 1'b0;
        bus.update_pc     = '0;
        bus.update_taken  = 1'b0;
        bus.update_target = '0;
        bus.invalidate    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_hit",    bus.pred_hit,    0);
        check("rst_taken",  bus.pred_taken,  0);
        check("rst_target", bus.pred_target, 16'h0041);
        check("rst_busy",   bus.busy,        0);
        check("rst_stl",    bus.stat_lookups, 0);
        pc_reset = 1'b0;

        upd(16'h0043, 1'b1, 16'h0100);
        look(16'h0043);
        check("alloc_hit",    bus.pred_hit,    1);
        check("alloc_taken",  bus.pred_taken,  1);
        check("alloc_target", bus.pred_target, 16'h0100);
        look(16'h0053);
        check("alias_hit",    bus.pred_hit,    0);
        check("alias_target", bus.pred_target, 16'h0054);

        bus.lookup_pc = 16'h0043;
        upd(16'h0043, 1'b0, 16'h0000);  // 10 -> 01
        #1 check("nt1_taken",  bus.pred_taken,  0);
        check("nt1_target", bus.pred_target, 16'h0044);
        upd(16'h0043, 1'b0, 16'h0000);  // 01 -> 00
        upd(16'h0043, 1'b0, 16'h0000);  // stays 00
        #1 check("nt3_hit",   bus.pred_hit,   1);
        upd(16'h0043, 1'b1, 16'h0100);  // 00 -> 01
        #1 check("t1_taken",  bus.pred_taken, 0);
        upd(16'h0043, 1'b1, 16'h0100);  // 01 -> 10
        #1 check("t2_taken",  bus.pred_taken, 1);
        check("t2_target", bus.pred_target, 16'h0100);

        @(negedge clk);
        bus.update_en     = 1'b1;
        bus.update_pc     = 16'h0043;
        bus.update_taken  = 1'b1;
        bus.update_target = 16'h0200;    // 10 -> 11
        #1 check("same_cycle_old", bus.pred_target, 16'h0100);
        @(negedge clk);
        bus.update_en = 1'b0;
        #1 check("same_cycle_new", bus.pred_target, 16'h0200);

        upd(16'h0043, 1'b1, 16'h0200);  // saturates at 11
        upd(16'h0043, 1'b0, 16'h0000);  // 11 -> 10
        #1 check("sat_hi_taken", bus.pred_taken, 1);
        upd(16'h0043, 1'b0, 16'h0000);  // 10 -> 01
        #1 check("sat_hi_nt", bus.pred_taken, 0);

        upd(16'h0077, 1'b0, 16'h0500);
        look(16'h0077);
        check("miss_nt_noalloc", bus.pred_hit, 0);

        upd(16'h0010, 1'b1, 16'h0110);
        upd(16'h0021, 1'b1, 16'h0121);
        upd(16'h0032, 1'b1, 16'h0132);
        look(16'h0032);
        check("fill_hit", bus.pred_hit, 1);

        bus.lookup_pc  = 16'h0043;
        bus.invalidate = 1'b1;
        @(negedge clk);
        bus.invalidate = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!bus.busy) break;
            cnt++;
            if (i == 0) check("busy_hit_forced", bus.pred_hit, 0);
            if (i == 2) begin
                bus.update_en     = 1'b1;
                bus.update_pc     = 16'h0050;
                bus.update_taken  = 1'b1;
                bus.update_target = 16'h0300;
                bus.invalidate    = 1'b1;
            end
            if (i == 3) begin
                bus.update_en  = 1'b0;
                bus.invalidate = 1'b0;
            end
            @(negedge clk);
        end
        check("busy_cycles", cnt, 16);
        look(16'h0010); check("clr_0010", bus.pred_hit, 0);
        look(16'h0021); check("clr_0021", bus.pred_hit, 0);
        look(16'h0032); check("clr_0032", bus.pred_hit, 0);
        look(16'h0043); check("clr_0043", bus.pred_hit, 0);
        look(16'h0050); check("upd_ignored", bus.pred_hit, 0);

        upd(16'h0043, 1'b1, 16'h0400);
        look(16'h0043);
        check("refill_hit", bus.pred_hit, 1);
        bus.invalidate = 1'b1;
        @(negedge clk);
        bus.invalidate = 1'b0;
        repeat (4) @(negedge clk);
        #1 check("clr2_busy", bus.busy, 1);
        #2 pc_reset = 1'b1;
        #1 check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_hit", bus.pred_hit, 0);
        @(negedge clk);
        pc_reset = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("post_rst_busy", bus.busy, 0);

        upd(16'h0043, 1'b1, 16'h0600);
        @(negedge clk);
        #1;
        sl0 = bus.stat_lookups;
        sh0 = bus.stat_hits;
        for (int i = 0; i < 10; i++) begin
            bus.lookup_pc = (i < 3) ? 16'h0043 : 16'h0099;
            @(negedge clk);
        end
        #1;
`ifdef BTB_STATS_EN
        check("stat_lookups", bus.stat_lookups - sl0, 10);
        check("stat_hits",    bus.stat_hits - sh0,    3);
`else
        check("stat_lookups", {sl0, bus.stat_lookups}, 0);
        check("stat_hits",    {sh0, bus.stat_hits},    0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
